spi_host_master: RTL and testbench
==================================

Name: spi_host_master

Overview:
- Host-side SPI master: drives `sck`/`cs`/`mosi`/`rw` into a board running processorci_top as SPI slave; samples `miso`; monitors the slave's `intr` callback line.
- Used in the bench/test-controller image that feeds programs into, and reads results from, a processor under test.
- SPI mode 0 (CPOL=0, CPHA=0), MSB first, one byte per transaction.

Parameters:
- CLK_DIV, 4: `sys_clk` cycles per SCK half-period. Legal range ≥ 2.
- DATA_WIDTH, 8: bits per transfer.

Ports:
- sys_clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request a transfer; accepted only when `busy`=0.
- tx_data  in  DATA_WIDTH  byte to shift out; captured at accept.
- rw_req  in  1  value to drive on `rw` for this transfer; captured at accept.
- busy  out  1  transfer in progress.
- done  out  1  one-cycle pulse when a transfer completes.
- rx_data  out  DATA_WIDTH  byte received; valid from `done`, held until the next `done`.
- intr_pending  out  1  sticky flag: slave raised `intr`.
- intr_clear  in  1  clears `intr_pending`.
- sck  out  1  SPI clock.
- cs  out  1  chip select, active low.
- mosi  out  1  master out.
- miso  in  1  master in (asynchronous to `sys_clk`).
- rw  out  1  SPI control line to slave.
- intr  in  1  slave interrupt (asynchronous to `sys_clk`).

Behaviour:
- Reset: asynchronous, active-low.
  - While `rst_n`=0: `sck`=0, `cs`=1, `mosi`=0, `rw`=0, `busy`=0, `done`=0, `rx_data`=0, `intr_pending`=0, FSM=IDLE, divider/bit counters=0.
  - Reset mid-transfer aborts immediately with no `done` pulse.
- FSM states: IDLE → SETUP → SHIFT → HOLD → IDLE.
- IDLE:
  - `start`=1 at edge T0 is accepted: capture `tx_data` and `rw_req`.
  - After T0: `busy`=1, `cs`=0, `rw`=`rw_req`, `mosi`=`tx_data`[MSB].
  - Go to SETUP.
- SETUP: lasts CLK_DIV cycles with `sck`=0, then go to SHIFT.
- SHIFT: 2·DATA_WIDTH half-periods of CLK_DIV cycles each; `sck` toggles at each half-period boundary, starting with a rising edge.
  - On each rising `sck` edge, shift `miso` into the receive shift register (LSB-in).
  - On each falling `sck` edge except the last, drive the next `mosi` bit.
  - After the final falling edge, `sck`=0; go to HOLD.
- HOLD: CLK_DIV cycles with `cs`=0, then return to IDLE.
  - On the IDLE-entry cycle: `cs`=1, `busy`=0, `done`=1 for exactly one cycle, `rx_data` updated.
  - `mosi`, `rw` keep their last values.
- Latency: `done` is high in the cycle after edge T0 + (2·DATA_WIDTH+2)·CLK_DIV. For CLK_DIV=4, DATA_WIDTH=8 that is T0+72.
- `start` while `busy`=1 is ignored; it is neither queued nor latched.
- `start` held high continuously: a new transfer is accepted in the `done` cycle, so there is at least one IDLE cycle with `cs`=1 between transfers.
- `miso` is sampled directly on the internal rising-edge cycle. At CLK_DIV ≥ 2 the slave has a full half-period to settle, so no synchronizer is used on data.
- `intr` handling:
  - `intr` passes through a 2-flop synchronizer.
  - A rising edge of the synchronized signal sets `intr_pending`.
  - `intr_clear`=1 clears it.
  - Set and clear in the same cycle: set wins.
  - `intr` is monitored in all states, including during transfers.

Optional Feature:
- Macro: SPI_BURST_EN.
- Defined:
  - Adds input port `last` (1 bit), captured at accept.
  - If `last`=0, the HOLD phase is skipped: after the final falling edge the FSM enters a WAIT state with `cs`=0, `sck`=0, `busy`=0, and pulses `done`.
  - In WAIT, a `start` goes directly to SHIFT (no SETUP). `rw` updates only if `rw_req` differs; the first rising edge comes CLK_DIV cycles after accept.
  - If `last`=1, the transfer ends with HOLD and `cs` deassert as normal.
  - Reset in WAIT forces `cs`=1.
- Undefined: no `last` port; every byte is individually framed by `cs` as described above.

Test Plan:
- Reset, then `start` with `tx_data`=0xA5, `rw_req`=1; bench slave returns 0x3C on `miso`.
  → `mosi` bits on rising `sck` edges are 1,0,1,0,0,1,0,1; `rw`=1 throughout; `rx_data`=0x3C; `done` one cycle at T0+72.
- Assert `start` at cycle 20 of a transfer.
  → Ignored; exactly one `done`; `cs` shows a single low window of 72 cycles.
- Pulse `rst_n`=0 in the middle of bit 4.
  → Immediately `cs`=1, `sck`=0, `busy`=0; no `done`; the next `start` completes normally with correct data.
- Raise `intr` for 3 cycles.
  → `intr_pending`=1 within 3 cycles and stays set.
  - Assert `intr_clear` on the same cycle as a new `intr` edge → `intr_pending` stays 1.
  - `intr_clear` alone → 0.
- `start` held high continuously for 3 transfers with 0x01, 0x80, 0xFF.
  → Three `done` pulses spaced 73 cycles apart; `cs` high for exactly 1 cycle between frames.
- With SPI_BURST_EN: send 2 bytes, `last`=0 then `last`=1.
  → `cs` low continuously across both bytes; no SETUP gap; `cs` rises CLK_DIV cycles after the second byte's last falling edge.

Source files
------------

// File: rtl/spi_host_master.sv
`default_nettype none
// spi_host_master: SPI mode-0 host master, MSB first, one DATA_WIDTH-bit word per transfer.
// Optional SPI_BURST_EN adds a 'last' input so that cs stays low across consecutive words.
module spi_host_master #(
   parameter int CLK_DIV    = 4,
   parameter int DATA_WIDTH = 8
) (
   input  logic                  sys_clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [DATA_WIDTH-1:0] tx_data,
   input  logic                  rw_req,
`ifdef SPI_BURST_EN
   input  logic                  last,
`endif
   output logic                  busy,
   output logic                  done,
   output logic [DATA_WIDTH-1:0] rx_data,
   output logic                  intr_pending,
   input  logic                  intr_clear,
   output logic                  sck,
   output logic                  cs,
   output logic                  mosi,
   input  logic                  miso,
   output logic                  rw,
   input  logic                  intr
);

   localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int HALF_W = (DATA_WIDTH > 1) ? $clog2(2 * DATA_WIDTH) : 1;
   localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
   localparam logic [HALF_W-1:0] HALF_LAST = HALF_W'(2 * DATA_WIDTH - 1);

`ifdef SPI_BURST_EN
   typedef enum logic [2:0] {ST_IDLE, ST_SETUP, ST_SHIFT, ST_HOLD, ST_WAIT} state_t;
   logic last_q;
`else
   typedef enum logic [1:0] {ST_IDLE, ST_SETUP, ST_SHIFT, ST_HOLD} state_t;
`endif

   state_t                state;
   logic [DIV_W-1:0]      div_cnt;
   logic [HALF_W-1:0]     half_cnt;
   logic [DATA_WIDTH-1:0] tx_shift;
   logic [DATA_WIDTH-1:0] rx_shift;
   logic                  intr_s1, intr_s2, intr_s3;

   wire div_end   = (div_cnt == DIV_LAST);
   wire last_half = (half_cnt == HALF_LAST);

   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= ST_IDLE;
         div_cnt  <= '0;
         half_cnt <= '0;
         tx_shift <= '0;
         rx_shift <= '0;
         sck      <= 1'b0;
         cs       <= 1'b1;
         mosi     <= 1'b0;
         rw       <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
         rx_data  <= '0;
`ifdef SPI_BURST_EN
         last_q   <= 1'b1;
`endif
      end else begin
         done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start) begin
                  // MSB goes straight onto mosi; tx_shift holds the bits still to send
                  tx_shift <= tx_data << 1;
                  mosi     <= tx_data[DATA_WIDTH-1];
                  rw       <= rw_req;
                  cs       <= 1'b0;
                  busy     <= 1'b1;
                  div_cnt  <= '0;
                  state    <= ST_SETUP;
`ifdef SPI_BURST_EN
                  last_q   <= last;
`endif
               end
            end
            ST_SETUP: begin
               if (div_end) begin
                  div_cnt  <= '0;
                  half_cnt <= '0;
                  state    <= ST_SHIFT;
               end else begin
                  div_cnt <= div_cnt + 1'b1;
               end
            end
            ST_SHIFT: begin
               if (div_end) begin
                  div_cnt  <= '0;
                  half_cnt <= half_cnt + 1'b1;
                  sck      <= ~sck;
                  if (!sck) begin
                     rx_shift <= DATA_WIDTH'({rx_shift, miso});
                  end else if (!last_half) begin
                     mosi     <= tx_shift[DATA_WIDTH-1];
                     tx_shift <= tx_shift << 1;
                  end
                  if (last_half) begin
                     state <= ST_HOLD;
`ifdef SPI_BURST_EN
                     if (!last_q) begin
                        state   <= ST_WAIT;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        rx_data <= rx_shift;
                     end
`endif
                  end
               end else begin
                  div_cnt <= div_cnt + 1'b1;
               end
            end
            ST_HOLD: begin
               if (div_end) begin
                  div_cnt <= '0;
                  cs      <= 1'b1;
                  busy    <= 1'b0;
                  done    <= 1'b1;
                  rx_data <= rx_shift;
                  state   <= ST_IDLE;
               end else begin
                  div_cnt <= div_cnt + 1'b1;
               end
            end
`ifdef SPI_BURST_EN
            ST_WAIT: begin
               // cs is still low: the next word skips SETUP
               if (start) begin
                  tx_shift <= tx_data << 1;
                  mosi     <= tx_data[DATA_WIDTH-1];
                  rw       <= rw_req;
                  busy     <= 1'b1;
                  div_cnt  <= '0;
                  half_cnt <= '0;
                  last_q   <= last;
                  state    <= ST_SHIFT;
               end
            end
`endif
            default: state <= ST_IDLE;
         endcase
      end
   end

   // intr is asynchronous: two synchronizer flops plus one for edge detection
   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         intr_s1      <= 1'b0;
         intr_s2      <= 1'b0;
         intr_s3      <= 1'b0;
         intr_pending <= 1'b0;
      end else begin
         intr_s1 <= intr;
         intr_s2 <= intr_s1;
         intr_s3 <= intr_s2;
         if (intr_s2 && !intr_s3) begin
            intr_pending <= 1'b1;
         end else if (intr_clear) begin
            intr_pending <= 1'b0;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_spi_host_master.sv
`default_nettype none
// tb_spi_host_master: directed/randomized bench with a word-level SPI slave model.
module tb_spi_host_master;

   localparam int CLK_DIV = 4;
   localparam int DW      = 8;
   localparam int IW      = $clog2(DW);
   localparam int LAT     = (2 * DW + 2) * CLK_DIV;

   logic          sys_clk    = 1'b0;
   logic          rst_n      = 1'b0;
   logic          start      = 1'b0;
   logic          rw_req     = 1'b0;
   logic          intr_clear = 1'b0;
   logic          intr       = 1'b0;
   logic [DW-1:0] tx_data    = '0;
   logic          miso;
   logic          busy, done, intr_pending, sck, cs, mosi, rw;
   logic [DW-1:0] rx_data;
`ifdef SPI_BURST_EN
   logic          last       = 1'b1;
`endif

   int tests = 0;
   int fails = 0;

   // slave model state
   logic [DW-1:0] slave_byte  = '0;
   logic [DW-1:0] mosi_cap    = '0;
   int            rise_cnt    = 0;
   int            fall_cnt    = 0;
   int            frame_fall0 = 0;
   int            done_cnt    = 0;
   int            sidx;

   spi_host_master #(.CLK_DIV(CLK_DIV), .DATA_WIDTH(DW)) dut (
      .sys_clk      (sys_clk),
      .rst_n        (rst_n),
      .start        (start),
      .tx_data      (tx_data),
      .rw_req       (rw_req),
`ifdef SPI_BURST_EN
      .last         (last),
`endif
      .busy         (busy),
      .done         (done),
      .rx_data      (rx_data),
      .intr_pending (intr_pending),
      .intr_clear   (intr_clear),
      .sck          (sck),
      .cs           (cs),
      .mosi         (mosi),
      .miso         (miso),
      .rw           (rw),
      .intr         (intr)
   );

   always #5 sys_clk = ~sys_clk;

   // Mode-0 slave: next bit appears after each falling sck edge, MSB first per word
   always @(negedge sck) fall_cnt <= fall_cnt + 1;
   always @(negedge cs)  frame_fall0 <= fall_cnt;
   always_comb begin
      sidx = DW - 1 - ((fall_cnt - frame_fall0) % DW);
      miso = slave_byte[IW'(sidx)];
   end
   always @(posedge sck) begin
      mosi_cap <= {mosi_cap[DW-2:0], mosi};
      rise_cnt <= rise_cnt + 1;
   end
   always @(posedge sys_clk) if (done === 1'b1) done_cnt <= done_cnt + 1;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      assert (got === exp) else begin
         fails++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // One framed transfer; optionally pulses start at cycle inject_at to show it is ignored
   task automatic run_xfer(input logic [DW-1:0] tx, input logic rwv, input logic [DW-1:0] sb,
                           input int inject_at);
      int lat, cs_low, rw_bad, r0;
      slave_byte = sb;
      r0 = rise_cnt;
      tx_data = tx; rw_req = rwv; start = 1'b1;
      @(posedge sys_clk); #1;
      start = 1'b0;
      lat = -1; cs_low = 0; rw_bad = 0;
      for (int k = 0; k <= LAT + 40; k++) begin
         start = (k == inject_at);
         if (done === 1'b1) begin lat = k; break; end
         if (cs === 1'b0) begin
            cs_low++;
            if (rw !== rwv) rw_bad++;
         end
         @(posedge sys_clk); #1;
      end
      start = 1'b0;
      check("xfer_latency", 32'(lat), 32'(LAT));
      check("xfer_cs_low_cycles", 32'(cs_low), 32'(LAT));
      check("xfer_rw_stable", 32'(rw_bad), 32'd0);
      check("xfer_rx_data", 32'(rx_data), 32'(sb));
      check("xfer_mosi_bits", 32'(mosi_cap), 32'(tx));
      check("xfer_sck_rises", 32'(rise_cnt - r0), 32'(DW));
      check("xfer_busy_at_done", 32'(busy), 32'd0);
      check("xfer_cs_at_done", 32'(cs), 32'd1);
      @(posedge sys_clk); #1;
      check("xfer_done_width", 32'(done), 32'd0);
   endtask

`ifdef SPI_BURST_EN
   task automatic burst_byte(input logic [DW-1:0] tx, input logic [DW-1:0] sb, input logic lastv);
      int lat, cs_high;
      check("burst_cs_before", 32'(cs), 32'(lastv ? 1'b0 : 1'b1) & 32'(cs));
      slave_byte = sb;
      tx_data = tx; rw_req = 1'b0; last = lastv; start = 1'b1;
      @(posedge sys_clk); #1;
      start = 1'b0;
      lat = -1; cs_high = 0;
      for (int k = 0; k <= LAT + 40; k++) begin
         if (done === 1'b1) begin lat = k; break; end
         if (cs !== 1'b0) cs_high++;
         @(posedge sys_clk); #1;
      end
      // from IDLE: SETUP + shift; from WAIT: shift + HOLD; both 2*DW+1 half-periods
      check("burst_latency", 32'(lat), 32'((2 * DW + 1) * CLK_DIV));
      check("burst_cs_high", 32'(cs_high), 32'd0);
      check("burst_rx", 32'(rx_data), 32'(sb));
      check("burst_mosi", 32'(mosi_cap), 32'(tx));
      check("burst_cs_at_done", 32'(cs), 32'(lastv));
      last = 1'b1;
   endtask
`endif

   int            first_set, r0, dc0, n, cs_high;
   int            dk [3];
   logic [DW-1:0] txs [3];
   logic [DW-1:0] sbs [3];

   initial begin
      // reset values
      #12;
      check("rst_sck", 32'(sck), 32'd0);
      check("rst_cs", 32'(cs), 32'd1);
      check("rst_mosi", 32'(mosi), 32'd0);
      check("rst_rw", 32'(rw), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_rx_data", 32'(rx_data), 32'd0);
      check("rst_intr_pending", 32'(intr_pending), 32'd0);
      @(posedge sys_clk); #1;
      rst_n = 1'b1;
      repeat (3) @(posedge sys_clk);
      #1;

      // basic transfer
      run_xfer(8'hA5, 1'b1, 8'h3C, -1);

      // start during a transfer is ignored
      dc0 = done_cnt;
      run_xfer(8'h5A, 1'b0, 8'hC3, 20);
      for (int k = 0; k < 80; k++) begin
         if (cs !== 1'b1) break;
         @(posedge sys_clk); #1;
      end
      check("ignored_start_cs_idle", 32'(cs), 32'd1);
      check("ignored_start_done_count", 32'(done_cnt - dc0), 32'd1);

      // reset in the middle of bit 4
      r0 = rise_cnt; dc0 = done_cnt;
      slave_byte = 8'($urandom); tx_data = 8'($urandom); rw_req = 1'b1; start = 1'b1;
      @(posedge sys_clk); #1;
      start = 1'b0;
      for (int k = 0; k < 200 && (rise_cnt - r0) < 4; k++) begin
         @(posedge sys_clk); #1;
      end
      check("rst_mid_reached_bit4", 32'(rise_cnt - r0), 32'd4);
      @(posedge sys_clk); #1;
      rst_n = 1'b0;
      #2;
      check("rst_mid_cs", 32'(cs), 32'd1);
      check("rst_mid_sck", 32'(sck), 32'd0);
      check("rst_mid_busy", 32'(busy), 32'd0);
      repeat (3) @(posedge sys_clk);
      #1 rst_n = 1'b1;
      repeat (5) @(posedge sys_clk);
      #1;
      check("rst_mid_no_done", 32'(done_cnt - dc0), 32'd0);
      run_xfer(8'($urandom), 1'b1, 8'($urandom), -1);

      // randomized transfers
      for (int i = 0; i < 4; i++) begin
         run_xfer(8'($urandom), 1'($urandom), 8'($urandom), -1);
      end

      // intr: pulse 3 cycles, then collision with clear, then clear alone
      first_set = -1;
      intr = 1'b1;
      for (int k = 1; k <= 6; k++) begin
         @(posedge sys_clk); #1;
         if (k == 3) intr = 1'b0;
         if (intr_pending === 1'b1 && first_set < 0) first_set = k;
      end
      check("intr_set_within_3", 32'(first_set >= 1 && first_set <= 3), 32'd1);
      check("intr_sticky", 32'(intr_pending), 32'd1);
      if (first_set < 1) first_set = 3;
      intr = 1'b1;
      for (int j = 0; j < first_set; j++) begin
         intr_clear = (j == first_set - 1);
         @(posedge sys_clk); #1;
      end
      intr_clear = 1'b0;
      check("intr_set_beats_clear", 32'(intr_pending), 32'd1);
      repeat (2) @(posedge sys_clk);
      #1 intr_clear = 1'b1;
      @(posedge sys_clk); #1;
      intr_clear = 1'b0;
      check("intr_clear_alone", 32'(intr_pending), 32'd0);
      intr = 1'b0;
      repeat (4) @(posedge sys_clk);
      #1;

      // start held high for three back-to-back transfers
      txs[0] = 8'h01; txs[1] = 8'h80; txs[2] = 8'hFF;
      for (int i = 0; i < 3; i++) begin
         sbs[i] = 8'($urandom);
         dk[i]  = -1000;
      end
      slave_byte = sbs[0]; tx_data = txs[0]; rw_req = 1'b1; start = 1'b1;
      n = 0; cs_high = 0;
      @(posedge sys_clk); #1;
      tx_data = txs[1];
      for (int k = 0; k <= 3 * (LAT + 1) + 40; k++) begin
         if (n > 0 && n < 2 && k == dk[n-1] + 1) tx_data = txs[n+1];
         if (done === 1'b1) begin
            dk[n] = k;
            check("b2b_rx", 32'(rx_data), 32'(sbs[n]));
            check("b2b_mosi", 32'(mosi_cap), 32'(txs[n]));
            n++;
            if (n < 3) slave_byte = sbs[n];
            else start = 1'b0;
         end
         if (n >= 3) break;
         if (cs === 1'b1) cs_high++;
         @(posedge sys_clk); #1;
      end
      start = 1'b0;
      check("b2b_count", 32'(n), 32'd3);
      check("b2b_first_latency", 32'(dk[0]), 32'(LAT));
      check("b2b_spacing_1", 32'(dk[1] - dk[0]), 32'(LAT + 1));
      check("b2b_spacing_2", 32'(dk[2] - dk[1]), 32'(LAT + 1));
      check("b2b_cs_high_cycles", 32'(cs_high), 32'd2);
      repeat (4) @(posedge sys_clk);
      #1;
      check("b2b_idle_after", 32'(busy), 32'd0);

`ifdef SPI_BURST_EN
      burst_byte(8'($urandom), 8'($urandom), 1'b0);
      burst_byte(8'($urandom), 8'($urandom), 1'b1);
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
`default_nettype wire
